// File: rtl/bit_serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings, FSM states, carry seed helper.
package bit_serial_alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NOTA = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Initial carry for an operation: cin only matters for ADD.
  function automatic logic carry_seed(input logic [1:0] op, input logic cin);
    return (op == OP_ADD) ? cin : 1'b0;
  endfunction

endpackage

// File: rtl/bit_serial_alu_if.sv
// Request/response bundle for bit_serial_alu.
// Optional ovf signal present only when BIT_SERIAL_ALU_OVF_EN is defined.
interface bit_serial_alu_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef BIT_SERIAL_ALU_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, op, a, b, cin,
`ifdef BIT_SERIAL_ALU_OVF_EN
    input  ovf,
`endif
    input  busy, done, result, cout
  );

  modport slave (
    input  start, op, a, b, cin,
`ifdef BIT_SERIAL_ALU_OVF_EN
    output ovf,
`endif
    output busy, done, result, cout
  );

endinterface

// File: rtl/bit_serial_alu_slice.sv
// One-bit ALU slice: AND / OR / NOT a / full-add, selected by {m1, m0}.
module bit_serial_alu_slice
  import bit_serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic carry_in,
  input  logic m0,
  input  logic m1,
  output logic y_c,
  output logic carry_c
);

  // Bit function; carry-out is only meaningful for ADD and is 0 otherwise.
  always_comb begin
    y_c     = 1'b0;
    carry_c = 1'b0;
    case ({m1, m0})
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_NOTA: y_c = ~a;
      OP_ADD: begin
        y_c     = a ^ b ^ carry_in;
        carry_c = (a & b) | (carry_in & (a ^ b));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: processes WIDTH-bit operands LSB first through one slice,
// one bit per cycle. Define BIT_SERIAL_ALU_OVF_EN to add the signed-overflow output.
module bit_serial_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  bit_serial_alu_if.slave bus
);

  import bit_serial_alu_pkg::*;

  localparam int unsigned     CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             accept_c;
  logic             last_c;
  logic             slice_y_c;
  logic             slice_carry_c;

  assign accept_c = (state == IDLE) && bus.start;
  assign last_c   = (state == RUN) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  bit_serial_alu_slice ALU_1_bit (
    .a        (a_q[cnt]),
    .b        (b_q[cnt]),
    .carry_in (carry_q),
    .m0       (op_q[0]),
    .m1       (op_q[1]),
    .y_c      (slice_y_c),
    .carry_c  (slice_carry_c)
  );

`ifdef BIT_SERIAL_ALU_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into MSB differs from carry out of MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_c) begin
      ovf_q <= (op_q == OP_ADD) && (carry_q ^ slice_carry_c);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  // Operand latch, serial shift, carry chain and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      carry_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      busy_q <= (state_next == RUN);
      done_q <= (state_next == DONE);
      if (accept_c) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        op_q    <= bus.op;
        carry_q <= carry_seed(bus.op, bus.cin);
        cnt     <= '0;
      end else if (state == RUN) begin
        result_q <= {slice_y_c, result_q[WIDTH-1:1]};
        carry_q  <= slice_carry_c;
        cnt      <= cnt + CNT_W'(1);
        if (last_c) begin
          cout_q <= (op_q == OP_ADD) && slice_carry_c;
        end
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu (WIDTH=8): directed corner cases,
// randomized operations, start-in-RUN, mid-run reset and back-to-back starts.
module tb_bit_serial_alu;

  import bit_serial_alu_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SW    = WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bit_serial_alu_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic cin);
    exp_t       e;
    logic [SW-1:0] sum;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (op)
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_NOTA: e.res = ~a;
      default: begin
        sum    = {1'b0, a} + {1'b0, b} + SW'(cin);
        e.res  = sum[WIDTH-1:0];
        e.cout = sum[WIDTH];
        e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, " result"}, 64'(bus.result), 64'(e.res));
    check({tag, " cout"}, 64'(bus.cout), 64'(e.cout));
`ifdef BIT_SERIAL_ALU_OVF_EN
    check({tag, " ovf"}, 64'(bus.ovf), 64'(e.ovf));
`endif
  endtask

  // Runs one operation from IDLE; called #1 after a rising edge.
  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin,
                        input bit disturb, input string tag);
    exp_t e;
    int   dones     = 0;
    int   done_edge = -1;
    e = model(op, a, b, cin);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " busy after accept"}, 64'(bus.busy), 64'(1));
    for (int i = 1; i <= WIDTH + 3; i++) begin
      if (disturb && i == 3) begin
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.a     = ~a;
        bus.b     = a ^ b;
        bus.cin   = ~cin;
      end
      if (disturb && i == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        if (done_edge < 0) done_edge = i;
      end
      if (i == WIDTH) begin
        check({tag, " busy in done"}, 64'(bus.busy), 64'(0));
        check_outputs(tag, e);
      end
    end
    check({tag, " latency"}, 64'(done_edge), 64'(WIDTH));
    check({tag, " done pulses"}, 64'(dones), 64'(1));
    check({tag, " result held"}, 64'(bus.result), 64'(e.res));
  endtask

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    int          dones;
    int          t [3];
    logic [1:0]  rop;
    logic [WIDTH-1:0] ra, rb;
    logic        rc;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_AND;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset result", 64'(bus.result), 64'(0));
    check("reset cout", 64'(bus.cout), 64'(0));
`ifdef BIT_SERIAL_ALU_OVF_EN
    check("reset ovf", 64'(bus.ovf), 64'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    run_op(OP_ADD, 8'h5A, 8'h3C, 1'b0, 1'b0, "add 5a+3c");
    run_op(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, "add ff+01");
    run_op(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, "add 7f+01");
    run_op(OP_ADD, 8'hFF, 8'hFF, 1'b1, 1'b0, "add ff+ff+1");
    run_op(OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b0, "and f0 3c");
    run_op(OP_OR,  8'hF0, 8'h3C, 1'b0, 1'b0, "or f0 3c");
    run_op(OP_NOTA, 8'h0F, 8'hA5, 1'b1, 1'b0, "not 0f");

    // start re-asserted during RUN with different operands must be ignored.
    run_op(OP_ADD, 8'h81, 8'h42, 1'b1, 1'b1, "start in run");

    // Randomized operations.
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rc  = 1'($urandom);
      run_op(rop, ra, rb, rc, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    // Reset during the 4th RUN cycle discards the operation.
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 8'h33;
    bus.b     = 8'h44;
    bus.cin   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst busy", 64'(bus.busy), 64'(0));
    check("midrst done", 64'(bus.done), 64'(0));
    check("midrst result", 64'(bus.result), 64'(0));
    check("midrst cout", 64'(bus.cout), 64'(0));
    dones = 0;
    for (int i = 0; i < WIDTH + 3; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("midrst no done", 64'(dones), 64'(0));
    run_op(OP_ADD, 8'h5A, 8'h3C, 1'b0, 1'b0, "after midrst");

    // start held high: one operation per IDLE visit, WIDTH+2 cycles apart.
    e = model(OP_ADD, 8'h12, 8'h34, 1'b1);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.cin   = 1'b1;
    dones = 0;
    for (int k = 0; k < 3; k++) t[k] = -100;
    for (int i = 1; i <= 4 * (WIDTH + 2) && dones < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        t[dones] = i;
        dones++;
        check("b2b result", 64'(bus.result), 64'(e.res));
      end
    end
    bus.start = 1'b0;
    check("b2b first latency", 64'(t[0]), 64'(WIDTH + 1));
    check("b2b period 1", 64'(t[1] - t[0]), 64'(WIDTH + 2));
    check("b2b period 2", 64'(t[2] - t[1]), 64'(WIDTH + 2));
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    check("final idle busy", 64'(bus.busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
